// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bus: decoded ID fields in, registered EX fields and stall out.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              id_valid;
    logic [9:0]        id_ctrl;
    logic [1:0]        id_reg_type;
    logic [2:0]        id_EXcntrl;
    logic [DATA_W-1:0] id_pc, id_rdA, id_rdB, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;

    logic              ex_valid;
    logic [9:0]        ex_ctrl;
    logic [1:0]        ex_reg_type;
    logic [2:0]        ex_EXcntrl;
    logic [DATA_W-1:0] ex_pc, ex_rdA, ex_rdB, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic              stall;
    logic              ex_fpu_busy;

    // Decode/redirect side: drives ID fields and flush, consumes EX state.
    modport master (
        output flush, id_valid, id_ctrl, id_reg_type, id_EXcntrl,
               id_pc, id_rdA, id_rdB, id_imm, id_rs1, id_rs2, id_rd,
        input  ex_valid, ex_ctrl, ex_reg_type, ex_EXcntrl,
               ex_pc, ex_rdA, ex_rdB, ex_imm, ex_rs1, ex_rs2, ex_rd,
               stall, ex_fpu_busy
    );

    // Stage register side.
    modport slave (
        input  flush, id_valid, id_ctrl, id_reg_type, id_EXcntrl,
               id_pc, id_rdA, id_rdB, id_imm, id_rs1, id_rs2, id_rd,
        output ex_valid, ex_ctrl, ex_reg_type, ex_EXcntrl,
               ex_pc, ex_rdA, ex_rdB, ex_imm, ex_rs1, ex_rs2, ex_rd,
               stall, ex_fpu_busy
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and a multi-cycle
// FPU hold. stall freezes PC and IF/ID while EX cannot accept a new op.
module id_ex_stage_reg #(
    parameter int         DATA_W   = 32,
    parameter int         FPU_LAT  = 4,
    parameter logic [2:0] FPU_CODE = 3'd5,
    parameter logic [2:0] ALU_R    = 3'd1
) (
    input logic         clock,
    input logic         reset,
    id_ex_stage_reg_if.slave bus
);
    // Counter must hold FPU_LAT-1 and still be valid when FPU_LAT == 1.
    localparam int CNT_W    = $clog2(FPU_LAT) + 1;
    localparam int MEM_READ = 7;   // MemRead position inside id_ctrl

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic              valid;
        logic [9:0]        ctrl;
        logic [1:0]        regType;
        logic [2:0]        exCntrl;
        logic [DATA_W-1:0] pc, rdA, rdB, imm;
        logic [4:0]        rs1, rs2, rd;
    } exFields_t;

    state_t     state;
    logic [CNT_W-1:0] cnt;
    exFields_t  exQ, idFields, bubble;
    logic       loadUse, isFpuOp;

    // Pack ID inputs and the canonical bubble for single-assignment loads.
    always_comb begin
        idFields         = '0;
        idFields.valid   = bus.id_valid;
        idFields.ctrl    = bus.id_ctrl;
        idFields.regType = bus.id_reg_type;
        idFields.exCntrl = bus.id_EXcntrl;
        idFields.pc      = bus.id_pc;
        idFields.rdA     = bus.id_rdA;
        idFields.rdB     = bus.id_rdB;
        idFields.imm     = bus.id_imm;
        idFields.rs1     = bus.id_rs1;
        idFields.rs2     = bus.id_rs2;
        idFields.rd      = bus.id_rd;
        bubble           = '0;
        bubble.exCntrl   = ALU_R;
    end

    // Load-use: a load in EX writes a register the ID op reads in the same
    // register class. x0 is hardwired so it never creates a dependency.
    always_comb begin
        loadUse = exQ.valid && exQ.ctrl[MEM_READ] && bus.id_valid &&
                  (exQ.regType == bus.id_reg_type) &&
                  ((exQ.rd == bus.id_rs1) || (exQ.rd == bus.id_rs2)) &&
                  !((exQ.regType == 2'd0) && (exQ.rd == 5'd0));
        isFpuOp = bus.id_valid && (bus.id_EXcntrl == FPU_CODE) && (FPU_LAT > 1);
    end

    assign bus.stall       = (state == BUSY) || (loadUse && !bus.flush);
    assign bus.ex_fpu_busy = (state == BUSY);

    // Stage register and FPU hold FSM: reset > flush > hold > bubble > load.
    always_ff @(posedge clock) begin
        if (reset) begin
            exQ   <= bubble;
            state <= IDLE;
            cnt   <= '0;
        end else if (bus.flush) begin
            exQ   <= bubble;
            state <= IDLE;
            cnt   <= '0;
        end else if (state == BUSY) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= IDLE;
        end else if (loadUse) begin
            exQ <= bubble;
        end else begin
            exQ <= bus.id_valid ? idFields : bubble;
            if (isFpuOp) begin
                state <= BUSY;
                cnt   <= CNT_W'(FPU_LAT - 1);
            end
        end
    end

    assign bus.ex_valid    = exQ.valid;
    assign bus.ex_ctrl     = exQ.ctrl;
    assign bus.ex_reg_type = exQ.regType;
    assign bus.ex_EXcntrl  = exQ.exCntrl;
    assign bus.ex_pc       = exQ.pc;
    assign bus.ex_rdA      = exQ.rdA;
    assign bus.ex_rdB      = exQ.rdB;
    assign bus.ex_imm      = exQ.imm;
    assign bus.ex_rs1      = exQ.rs1;
    assign bus.ex_rs2      = exQ.rs2;
    assign bus.ex_rd       = exQ.rd;
endmodule
